// File: rtl/adder_pipe_acc.sv
// adder_pipe_acc: pipelined add / subtract / accumulate unit with valid/ready handshakes.
//
// Arithmetic is evaluated when an input is accepted and registered into stage 1; the remaining
// stages only delay the result. The accumulator updates on the accepting edge, so back-to-back
// accumulate operations chain without hazards, whatever the output stalls.
//
// Ports:
//   clk_i    rising-edge clock
//   rst_i    asynchronous active-high reset
//   valid_i  input operands valid            ready_o  input can be accepted this cycle
//   a_i      operand A                       b_i      operand B (unused for acc/clear)
//   cin_i    carry-in / borrow-in            mode_i   0 add, 1 sub, 2 accumulate, 3 clear acc
//   valid_o  result valid                    ready_i  downstream takes the result
//   s_o      result                          cout_o   carry-out, or no-borrow for sub
//   ovf_o    signed overflow                 acc_o    current accumulator value
`timescale 1ns/1ps
module adder_pipe_acc #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic [1:0]       mode_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic [WIDTH-1:0] acc_o
);

  typedef enum logic [1:0] {
    ModeAdd = 2'd0,
    ModeSub = 2'd1,
    ModeAcc = 2'd2,
    ModeClr = 2'd3
  } mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             cin_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_s;
  logic             res_cout;
  logic             res_ovf;
  logic             adv;
  logic             accept;

  // Per-stage pipeline registers; index PIPE_STAGES-1 drives the outputs.
  logic             vld_q  [PIPE_STAGES];
  logic [WIDTH-1:0] s_q    [PIPE_STAGES];
  logic             cout_q [PIPE_STAGES];
  logic             ovf_q  [PIPE_STAGES];

  assign mode = mode_e'(mode_i);

  // Whole pipeline moves together, bubbles included, unless the output is held.
  assign adv     = !vld_q[PIPE_STAGES-1] || ready_i;
  assign ready_o = adv;
  assign accept  = valid_i && adv;

  always_comb begin
    op1     = a_i;
    op2     = b_i;
    cin_eff = cin_i;
    case (mode)
      ModeSub: begin
        // a - b - borrow computed as a + ~b + !borrow; carry out means no borrow.
        op2     = ~b_i;
        cin_eff = ~cin_i;
      end
      ModeAcc: begin
        op1 = acc_q;
        op2 = a_i;
      end
      default: ;
    endcase

    sum = {1'b0, op1} + {1'b0, op2} + {{WIDTH{1'b0}}, cin_eff};

    if (mode == ModeClr) begin
      res_s    = '0;
      res_cout = 1'b0;
      res_ovf  = 1'b0;
    end else begin
      res_s    = sum[WIDTH-1:0];
      res_cout = sum[WIDTH];
      res_ovf  = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
    end
  end

  // Accumulator follows acceptance, not output consumption.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else if (accept && (mode == ModeAcc)) begin
      acc_q <= sum[WIDTH-1:0];
    end else if (accept && (mode == ModeClr)) begin
      acc_q <= '0;
    end
  end

  // Data registers load only alongside a valid entry so s_o keeps its last value under bubbles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
        vld_q[i]  <= 1'b0;
        s_q[i]    <= '0;
        cout_q[i] <= 1'b0;
        ovf_q[i]  <= 1'b0;
      end
    end else if (adv) begin
      vld_q[0] <= accept;
      if (accept) begin
        s_q[0]    <= res_s;
        cout_q[0] <= res_cout;
        ovf_q[0]  <= res_ovf;
      end
      for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          s_q[i]    <= s_q[i-1];
          cout_q[i] <= cout_q[i-1];
          ovf_q[i]  <= ovf_q[i-1];
        end
      end
    end
  end

  assign valid_o = vld_q[PIPE_STAGES-1];
  assign s_o     = s_q[PIPE_STAGES-1];
  assign cout_o  = cout_q[PIPE_STAGES-1];
  assign ovf_o   = ovf_q[PIPE_STAGES-1];
  assign acc_o   = acc_q;

endmodule

// File: tb/tb_adder_pipe_acc.sv
`timescale 1ns/1ps
module tb_adder_pipe_acc;

  localparam int P8  = 2;
  localparam int P16 = 1;

  typedef struct {
    longint s;
    longint cout;
    longint ovf;
    int     cyc;
    bit     lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_i;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   rdy_mode = 0;

  // 8-bit, 2-stage instance
  logic       valid_i, ready_o, cin_i, valid_o, ready_i, cout_o, ovf_o;
  logic [7:0] a_i, b_i, s_o, acc_o;
  logic [1:0] mode_i;
  // 16-bit, 1-stage instance
  logic        valid16_i, ready16_o, cin16, valid16_o, ready16_i, cout16, ovf16;
  logic [15:0] a16, b16, s16, acc16;
  logic [1:0]  mode16;

  exp_t   q8[$];
  exp_t   q16[$];
  exp_t   e8, e16;
  longint m_acc = 0;
  longint m_acc16 = 0;
  bit     stall8 = 0;
  logic [7:0] s_hold;

  adder_pipe_acc #(.WIDTH(8), .PIPE_STAGES(P8)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .a_i(a_i), .b_i(b_i),
    .cin_i(cin_i), .mode_i(mode_i), .valid_o(valid_o), .ready_i(ready_i), .s_o(s_o),
    .cout_o(cout_o), .ovf_o(ovf_o), .acc_o(acc_o)
  );

  adder_pipe_acc #(.WIDTH(16), .PIPE_STAGES(P16)) u_dut16 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid16_i), .ready_o(ready16_o), .a_i(a16), .b_i(b16),
    .cin_i(cin16), .mode_i(mode16), .valid_o(valid16_o), .ready_i(ready16_i), .s_o(s16),
    .cout_o(cout16), .ovf_o(ovf16), .acc_o(acc16)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Downstream readiness changes shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       ready_i = 1'b1;
      1:       ready_i = 1'($urandom_range(0, 1));
      default: ready_i = 1'b0;
    endcase
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sx(input longint v, input int w);
    longint half;
    half = longint'(1) << (w - 1);
    return (v >= half) ? v - 2 * half : v;
  endfunction

  // Reference: plain integer arithmetic, signed overflow by range check on the true result.
  function automatic void ref_op(input int w, input int mode, input longint a, input longint b,
                                 input longint cin, inout longint acc, output longint s,
                                 output longint cout, output longint ovf);
    longint m, half, full, sr;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    s = 0; cout = 0; sr = 0; full = 0;
    case (mode)
      0: begin
        full = a + b + cin; sr = sx(a, w) + sx(b, w) + cin;
        s = full & m; cout = (full > m) ? 1 : 0;
      end
      1: begin
        full = a - b - cin; sr = sx(a, w) - sx(b, w) - cin;
        s = full & m; cout = (full >= 0) ? 1 : 0;
      end
      2: begin
        full = acc + a + cin; sr = sx(acc, w) + sx(a, w) + cin;
        s = full & m; cout = (full > m) ? 1 : 0; acc = s;
      end
      default: acc = 0;
    endcase
    ovf = (sr < -half || sr >= half) ? 1 : 0;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input int mode, input int a, input int b, input int cin, input bit lat);
    exp_t e;
    int   n;
    valid_i = 1'b1; mode_i = 2'(mode); a_i = 8'(a); b_i = 8'(b); cin_i = 1'(cin);
    n = 0;
    while (!ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) check("ready_timeout", longint'(ready_o), 1);
    ref_op(8, mode, longint'(a), longint'(b), longint'(cin), m_acc, e.s, e.cout, e.ovf);
    e.cyc = cyc + P8;
    e.lat = lat;
    q8.push_back(e);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic send16(input int mode, input int a, input int b, input int cin, input bit lat);
    exp_t e;
    int   n;
    valid16_i = 1'b1; mode16 = 2'(mode); a16 = 16'(a); b16 = 16'(b); cin16 = 1'(cin);
    n = 0;
    while (!ready16_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready16_o) check("ready16_timeout", longint'(ready16_o), 1);
    ref_op(16, mode, longint'(a), longint'(b), longint'(cin), m_acc16, e.s, e.cout, e.ovf);
    e.cyc = cyc + P16;
    e.lat = lat;
    q16.push_back(e);
    @(negedge clk);
    valid16_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_q8", longint'(q8.size()), 0);
    check("drain_q16", longint'(q16.size()), 0);
  endtask

  // Monitor for the 8-bit instance: pops on each output transfer, checks holds during stalls.
  always @(negedge clk) begin
    if (rst_i) begin
      stall8 = 1'b0;
    end else begin
      if (stall8) begin
        check("stall_s_hold", longint'(s_o), longint'(s_hold));
        check("stall_valid_hold", longint'(valid_o), 1);
      end
      if (valid_o && ready_i) begin
        if (q8.size() == 0) begin
          check("unexpected_out8", longint'(q8.size()), 1);
        end else begin
          e8 = q8.pop_front();
          check("s8", longint'(s_o), e8.s);
          check("cout8", longint'(cout_o), e8.cout);
          check("ovf8", longint'(ovf_o), e8.ovf);
          if (e8.lat) check("latency8", longint'(cyc), longint'(e8.cyc));
        end
      end
      stall8 = valid_o && !ready_i;
      s_hold = s_o;
    end
  end

  always @(negedge clk) begin
    if (!rst_i && valid16_o && ready16_i) begin
      if (q16.size() == 0) begin
        check("unexpected_out16", longint'(q16.size()), 1);
      end else begin
        e16 = q16.pop_front();
        check("s16", longint'(s16), e16.s);
        check("cout16", longint'(cout16), e16.cout);
        check("ovf16", longint'(ovf16), e16.ovf);
        if (e16.lat) check("latency16", longint'(cyc), longint'(e16.cyc));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    valid_i = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0; mode_i = '0;
    valid16_i = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; mode16 = '0; ready16_i = 1'b1;
    ready_i = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", longint'(valid_o), 0);
    check("rst_s", longint'(s_o), 0);
    check("rst_acc", longint'(acc_o), 0);
    check("rst_ready", longint'(ready_o), 1);
    check("rst_valid16", longint'(valid16_o), 0);
    #1 rst_i = 1'b0;
    @(negedge clk);

    // Carry out of 0xFF + 1, then subtract with and without borrow-out.
    send(0, 'hFF, 'h01, 0, 1);
    send(1, 'h80, 'h01, 0, 1);
    send(1, 'h00, 'h01, 0, 1);
    // Accumulator chain starting from a clear.
    send(3, 0, 0, 0, 1);
    send(2, 'h10, 0, 0, 1);
    send(2, 'h20, 0, 0, 1);
    send(2, 'hF0, 0, 0, 1);
    drain();
    check("acc_after_chain", longint'(acc_o), m_acc);
    check("acc_chain_value", longint'(acc_o), 'h20);

    // Output stall while streaming five adds.
    fork
      begin
        for (int i = 1; i <= 5; i++) send(0, i, i, 0, 0);
      end
      begin
        @(negedge clk);
        rdy_mode = 2;
        repeat (4) @(negedge clk);
        check("stall_ready_low", longint'(ready_o), 0);
        check("stall_valid_high", longint'(valid_o), 1);
        rdy_mode = 0;
      end
    join
    drain();

    // Reset between edges with results in flight.
    send(3, 0, 0, 0, 1);
    send(2, 'h33, 0, 0, 1);
    send(0, 1, 1, 0, 1);
    send(0, 2, 2, 0, 1);
    check("acc_before_reset", longint'(acc_o), m_acc);
    #2 rst_i = 1'b1;
    #1;
    check("midrst_valid", longint'(valid_o), 0);
    check("midrst_s", longint'(s_o), 0);
    check("midrst_acc", longint'(acc_o), 0);
    check("midrst_cout", longint'(cout_o), 0);
    q8.delete();
    m_acc = 0;
    @(negedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    send(0, 5, 6, 0, 1);
    drain();

    // Wide, single-stage instance.
    send16(0, 'h7FFF, 'h0001, 0, 1);
    send16(0, 'hFFFF, 'h0000, 1, 1);
    for (int i = 0; i < 20; i++) begin
      send16(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)),
             int'($urandom_range(0, 65535)), int'($urandom_range(0, 1)), 1);
    end
    drain();
    check("acc16_final", longint'(acc16), m_acc16);

    // Random traffic with random downstream readiness and input gaps.
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rdy_mode = 0;
    drain();
    check("acc_final", longint'(acc_o), m_acc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
